// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32 core: fetch/decode/exec/mem/wb sequencing,
// PC advance, retired-instruction count and a sticky memory-handshake timeout fault.
module core_sequencer #(
  parameter int unsigned           PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter int unsigned           MEM_TIMEOUT = 16,
  parameter int unsigned           CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  output logic                 ir_load,
  input  logic [6:0]           opcode,
  input  logic                 dec_reg_write,
  input  logic                 dec_mem_write,
  input  logic                 dec_mem_to_reg,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 illegal,
  output logic                 fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam int unsigned      WCW       = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  logic [2:0]           state, state_d;
  logic [PC_WIDTH-1:0]  pc_d;
  logic [CNT_WIDTH-1:0] instret_d;
  logic                 fault_d;
  logic [WCW-1:0]       wait_cnt, wait_d;
  logic                 supported;
  logic [PC_WIDTH-1:0]  pc_next;
  logic [CNT_WIDTH-1:0] instret_next;

  assign supported    = (opcode == 7'b0110011) || (opcode == 7'b0000011) ||
                        (opcode == 7'b0010011) || (opcode == 7'b0100011);
  assign pc_next      = pc + PC_WIDTH'(4);
  assign instret_next = instret + CNT_WIDTH'(1);
  assign imem_addr    = pc;

  // Strobes depend only on the registered state, so an async reset drops them at once.
  always_comb begin
    imem_req = (state == S_FETCH);
    ir_load  = (state == S_FETCH) && imem_ack;
    illegal  = (state == S_DECODE) && !supported;
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && dec_mem_write;
    rf_we    = (state == S_WB) && dec_reg_write;
    wb_sel   = (state == S_WB) && dec_mem_to_reg;
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    instret_d = instret;
    fault_d   = fault;
    wait_d    = wait_cnt;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // An ack in the terminal wait cycle is checked first, so it wins over the timeout.
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_cnt + WCW'(1);
        end
      end
      S_DECODE: begin
        if (supported) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
          pc_d    = pc_next;
        end
      end
      S_EXEC: begin
        if (dec_mem_write || dec_mem_to_reg) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (dec_mem_write) begin
            state_d   = S_IDLE;
            pc_d      = pc_next;
            instret_d = instret_next;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_cnt + WCW'(1);
        end
      end
      S_WB: begin
        state_d   = S_IDLE;
        pc_d      = pc_next;
        instret_d = instret_next;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instret  <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      instret  <= instret_d;
      fault    <= fault_d;
      wait_cnt <= wait_d;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle vector table for the main instruction flows,
// hand sequences for handshake timeout, terminal-cycle ack, PC wrap and mid-operation reset.
module tb_core_sequencer;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic        dec_reg_write, dec_mem_write, dec_mem_to_reg;
  logic        imem_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel, illegal, fault;
  logic [31:0] imem_addr, pc, instret;
  logic        w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_rf_we, w_wb_sel, w_illegal, w_fault;
  logic [31:0] w_imem_addr, w_pc, w_instret;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .ir_load(ir_load), .opcode(opcode), .dec_reg_write(dec_reg_write),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc),
    .instret(instret), .illegal(illegal), .fault(fault)
  );

  // Second instance starts 4 bytes below zero so its pc wraps on the first retirement.
  core_sequencer #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) u_wrap (
    .clk(clk), .rst(rst), .run(run), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .ir_load(w_ir_load), .opcode(opcode), .dec_reg_write(dec_reg_write),
    .dec_mem_write(dec_mem_write), .dec_mem_to_reg(dec_mem_to_reg), .dmem_req(w_dmem_req),
    .dmem_we(w_dmem_we), .dmem_ack(dmem_ack), .rf_we(w_rf_we), .wb_sel(w_wb_sel), .pc(w_pc),
    .instret(w_instret), .illegal(w_illegal), .fault(w_fault)
  );

  typedef struct {
    logic        run, iack;
    logic [6:0]  op;
    logic        rw, mw, m2r, dack;
    logic [6:0]  strb;   // {imem_req, ir_load, illegal, dmem_req, dmem_we, rf_we, wb_sel}
    logic [31:0] pc, ir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ia, input logic [6:0] o,
                              input logic w, input logic m, input logic l, input logic da,
                              input logic [6:0] s, input logic [31:0] p, input logic [31:0] n);
    vec_t v;
    v.run = r; v.iack = ia; v.op = o; v.rw = w; v.mw = m; v.m2r = l; v.dack = da;
    v.strb = s; v.pc = p; v.ir = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ia, input logic [6:0] o,
                       input logic w, input logic m, input logic l, input logic da);
    run = r; imem_ack = ia; opcode = o;
    dec_reg_write = w; dec_mem_write = m; dec_mem_to_reg = l; dmem_ack = da;
  endtask

  function automatic logic [6:0] strobes();
    return {imem_req, ir_load, illegal, dmem_req, dmem_we, rf_we, wb_sel};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, OP_ADDI, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, OP_ADDI, 0, 0, 0, 0);
    #1;
    check("reset_strobes", 32'(strobes()), 32'h0);
    check("reset_pc", pc, 32'h0);
    check("reset_instret", instret, 32'h0);
    check("reset_fault", 32'(fault), 32'h0);
    check("reset_wrap_pc", w_pc, 32'hFFFF_FFFC);

    // ADDI with imem_ack on the second fetch cycle (run dropped meanwhile)
    tbl.push_back(mk(1, 0, OP_ADDI, 1, 0, 0, 0, 7'b0000000,  0, 0));
    tbl.push_back(mk(0, 0, OP_ADDI, 1, 0, 0, 0, 7'b1000000,  0, 0));
    tbl.push_back(mk(0, 1, OP_ADDI, 1, 0, 0, 0, 7'b1100000,  0, 0));
    tbl.push_back(mk(0, 0, OP_ADDI, 1, 0, 0, 0, 7'b0000000,  0, 0));
    tbl.push_back(mk(0, 0, OP_ADDI, 1, 0, 0, 0, 7'b0000000,  0, 0));
    tbl.push_back(mk(0, 0, OP_ADDI, 1, 0, 0, 0, 7'b0000010,  0, 0));
    // LW, stray dmem_ack in DECODE ignored, dmem_ack on third MEM cycle
    tbl.push_back(mk(1, 0, OP_LW,   1, 0, 1, 0, 7'b0000000,  4, 1));
    tbl.push_back(mk(0, 1, OP_LW,   1, 0, 1, 0, 7'b1100000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 1, 7'b0000000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 0, 7'b0000000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 0, 7'b0001000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 0, 7'b0001000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 1, 7'b0001000,  4, 1));
    tbl.push_back(mk(0, 0, OP_LW,   1, 0, 1, 0, 7'b0000011,  4, 1));
    // SW with immediate dmem_ack
    tbl.push_back(mk(1, 0, OP_SW,   0, 1, 0, 0, 7'b0000000,  8, 2));
    tbl.push_back(mk(0, 1, OP_SW,   0, 1, 0, 0, 7'b1100000,  8, 2));
    tbl.push_back(mk(0, 0, OP_SW,   0, 1, 0, 0, 7'b0000000,  8, 2));
    tbl.push_back(mk(0, 0, OP_SW,   0, 1, 0, 0, 7'b0000000,  8, 2));
    tbl.push_back(mk(0, 0, OP_SW,   0, 1, 0, 1, 7'b0001100,  8, 2));
    tbl.push_back(mk(0, 0, OP_SW,   0, 1, 0, 0, 7'b0000000, 12, 3));
    // Unsupported opcode; acks in IDLE ignored afterwards
    tbl.push_back(mk(1, 0, OP_BAD,  0, 0, 0, 0, 7'b0000000, 12, 3));
    tbl.push_back(mk(0, 1, OP_BAD,  0, 0, 0, 0, 7'b1100000, 12, 3));
    tbl.push_back(mk(0, 0, OP_BAD,  0, 0, 0, 0, 7'b0010000, 12, 3));
    tbl.push_back(mk(0, 1, OP_BAD,  0, 0, 0, 1, 7'b0000000, 16, 3));
    // R-type ALU op
    tbl.push_back(mk(1, 0, OP_R,    1, 0, 0, 0, 7'b0000000, 16, 3));
    tbl.push_back(mk(0, 1, OP_R,    1, 0, 0, 0, 7'b1100000, 16, 3));
    tbl.push_back(mk(0, 0, OP_R,    1, 0, 0, 0, 7'b0000000, 16, 3));
    tbl.push_back(mk(0, 0, OP_R,    1, 0, 0, 0, 7'b0000000, 16, 3));
    tbl.push_back(mk(0, 0, OP_R,    1, 0, 0, 0, 7'b0000010, 16, 3));
    tbl.push_back(mk(0, 0, OP_R,    1, 0, 0, 0, 7'b0000000, 20, 4));

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].iack, tbl[i].op, tbl[i].rw, tbl[i].mw, tbl[i].m2r, tbl[i].dack);
      #1;
      check($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(tbl[i].strb));
      check($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].pc);
      check($sformatf("vec%0d_instret", i), instret, tbl[i].ir);
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'h0);
      check($sformatf("vec%0d_wrap_pc", i), w_pc, tbl[i].pc + 32'hFFFF_FFFC);
    end

    // dmem timeout: 16 MEM cycles without ack, then sticky fault
    do_reset();
    drive(1, 0, OP_LW, 1, 0, 1, 0);
    @(negedge clk); drive(0, 1, OP_LW, 1, 0, 1, 0);
    @(negedge clk); drive(0, 0, OP_LW, 1, 0, 1, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check($sformatf("to_mem%0d_dmem_req", i), 32'(dmem_req), 32'h1);
      check($sformatf("to_mem%0d_fault", i), 32'(fault), 32'h0);
    end
    @(negedge clk); #1;
    check("to_fault_set", 32'(fault), 32'h1);
    check("to_fault_strobes", 32'(strobes()), 32'h0);
    drive(1, 1, OP_LW, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("to_late%0d_strobes", i), 32'(strobes()), 32'h0);
      check($sformatf("to_late%0d_fault", i), 32'(fault), 32'h1);
      check($sformatf("to_late%0d_pc", i), pc, 32'h0);
      check($sformatf("to_late%0d_instret", i), instret, 32'h0);
    end
    rst = 1'b1; #1;
    check("to_rst_fault", 32'(fault), 32'h0);
    check("to_rst_pc", pc, 32'h0);

    // SW with dmem_ack in the terminal wait cycle: no fault, store retires
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, OP_SW, 0, 1, 0, 0);
    @(negedge clk); drive(0, 1, OP_SW, 0, 1, 0, 0);
    @(negedge clk); drive(0, 0, OP_SW, 0, 1, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dmem_ack = (i == 15);
      #1;
      check($sformatf("term_mem%0d_dmem_we", i), 32'(dmem_we), 32'h1);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("term_fault", 32'(fault), 32'h0);
    check("term_instret", instret, 32'h1);
    check("term_pc", pc, 32'h4);
    check("term_strobes", 32'(strobes()), 32'h0);

    // Async reset in the middle of a MEM wait
    drive(1, 0, OP_LW, 1, 0, 1, 0);
    @(negedge clk); drive(0, 1, OP_LW, 1, 0, 1, 0);
    @(negedge clk); drive(0, 0, OP_LW, 1, 0, 1, 0);
    @(negedge clk);
    @(negedge clk); #1;
    check("midrst_pre_dmem_req", 32'(dmem_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("midrst_dmem_req", 32'(dmem_req), 32'h0);
    check("midrst_instret", instret, 32'h0);
    check("midrst_pc", pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, OP_ADDI, 1, 0, 0, 0);
    #1;
    check("midrst_idle", 32'(strobes()), 32'h0);

    // imem timeout: fetch held 16 cycles without ack
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      check($sformatf("ito_fetch%0d_imem_req", i), 32'(imem_req), 32'h1);
    end
    @(negedge clk); #1;
    check("ito_fault", 32'(fault), 32'h1);
    check("ito_imem_req", 32'(imem_req), 32'h0);

    rst = 1'b1;
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
